p_encoder_stream: RTL and testbench
===================================

// Module: p_encoder_stream
// PURPOSE
//  Parametrised, handshaked priority encoder. Accepts one WIDTH-bit request vector
//  per transaction and emits the index of every set bit, one beat per bit, in
//  priority order, flagging the final beat. Sits between request-collection logic
//  and a serial consumer such as an interrupt dispatcher or a grant sequencer.
// PARAMETERS
//  WIDTH      8                 request vector width; WIDTH >= 2
//  MSB_FIRST  1                 1: highest set index emitted first; 0: lowest first
//  IDXW       $clog2(WIDTH)     derived localparam; index width
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        synchronous reset, active-low
//  in_valid   in   1        in_vec is valid
//  in_ready   out  1        block accepts a vector this cycle
//  in_vec     in   WIDTH    request vector
//  out_valid  out  1        out_idx/out_last/out_none are valid
//  out_ready  in   1        consumer accepts the current beat
//  out_idx    out  IDXW     index of the current set bit
//  out_last   out  1        current beat is the last beat for this vector
//  out_none   out  1        captured vector was all-zero
//  pop_count  out  IDXW+1   set-bit count of the captured vector (PENC_POPCOUNT_EN only)
// BEHAVIOUR
//  - FSM states: IDLE and SCAN. Register pend[WIDTH] holds the bits still to be emitted.
//  - Reset (rst_n=0 at a clk edge): state=IDLE, pend=0, out_valid=0, out_idx=0,
//    out_last=0, out_none=0, pop_count=0. in_ready=0 while rst_n=0.
//  - in_ready = (state==IDLE) && rst_n. No other path asserts in_ready.
//  - IDLE: on in_valid && in_ready, capture pend<=in_vec and go to SCAN.
//    out_valid rises on the next cycle (latency 1).
//  - SCAN: out_valid=1.
//    - out_idx is the highest set index of pend (MSB_FIRST=1) or the lowest (MSB_FIRST=0).
//    - out_last=1 iff popcount(pend) <= 1.
//  - On out_valid && out_ready in SCAN: clear pend[out_idx].
//    - If out_last=1: go to IDLE; out_valid=0 next cycle.
//    - Otherwise stay in SCAN and present the next index.
//  - Throughput: k beats for k set bits, then one IDLE cycle before the next vector is
//    accepted. Back-to-back vectors therefore cost k+1 cycles.
//  - Zero vector: accepted normally. SCAN emits exactly one beat with out_idx=0,
//    out_none=1, out_last=1. out_none=0 for every beat of any non-zero vector.
//  - Backpressure: while out_valid && !out_ready, out_idx, out_last and out_none hold
//    stable.
//  - in_valid asserted during SCAN is ignored (in_ready=0). The source must hold
//    in_vec until accepted.
//  - When out_valid=0: out_idx, out_last and out_none are driven 0.
//  - Reset mid-burst: pending bits are discarded; the next cycle shows IDLE/reset
//    values and no partial beat is emitted.
//  - Index comparisons use the full IDXW width. Indices >= WIDTH are never produced
//    for non-power-of-2 WIDTH.
// CONFIGURATION
//  - PENC_POPCOUNT_EN defined:
//    - Port pop_count exists.
//    - It is loaded with popcount(in_vec) on accept and held constant for all beats
//      of that vector (0 for a zero vector).
//    - It returns to 0 when state returns to IDLE.
//  - PENC_POPCOUNT_EN undefined: port pop_count and its logic are absent; all other
//    behaviour is identical.
// TESTING  (WIDTH=8 unless noted)
//  1. MSB_FIRST=1, in_vec=8'b1010_0110, out_ready=1
//     -> beats idx 7,5,2,1 on 4 consecutive cycles, out_last only on idx 1;
//        in_ready=1 one cycle later.
//  2. in_vec=8'h00
//     -> single beat: out_idx=0, out_none=1, out_last=1; then IDLE.
//  3. in_vec=8'h81, out_ready=0 for 3 cycles, then 1
//     -> idx 7 held stable with out_last=0 for 4 cycles, then idx 0 with out_last=1.
//  4. MSB_FIRST=0, in_vec=8'b1010_0110
//     -> beats idx 1,2,5,7; last on idx 7.
//     WIDTH=5, in_vec=5'b10001 -> idx 0,4.
//  5. in_vec=8'hFF; pull rst_n low for 1 cycle after the first beat
//     -> out_valid=0 next cycle and in_ready=1 after release;
//        new in_vec=8'h10 -> one beat idx 4, out_last=1.
//  6. PENC_POPCOUNT_EN defined, in_vec=8'b1010_0110
//     -> pop_count=4 on every beat, 0 after return to IDLE;
//        in_valid held high during SCAN never yields in_ready=1.

Source files
------------

// File: rtl/p_encoder_stream_if.sv
// rtl/p_encoder_stream_if.sv - request/beat handshake bundle for p_encoder_stream (PENC_POPCOUNT_EN adds pop_count)
interface p_encoder_stream_if #(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic             out_none;
`ifdef PENC_POPCOUNT_EN
    logic [IDXW:0]    pop_count;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_none, pop_count
    );
    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_none, pop_count
    );
`else
    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_none
    );
    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_none
    );
`endif
endinterface

// File: rtl/p_encoder_stream.sv
// rtl/p_encoder_stream.sv - handshaked priority encoder emitting one beat per set bit; PENC_POPCOUNT_EN adds pop_count
module p_encoder_stream #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    p_encoder_stream_if.slave  bus
);
    localparam int IDXW = $clog2(WIDTH);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] sel_mask;
    logic [IDXW-1:0]  enc_idx;
    logic             single;

    // Later matches overwrite earlier ones, so the loop direction sets priority.
    always_comb begin
        enc_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++)
                if (pend_q[i]) enc_idx = IDXW'(i);
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (pend_q[i]) enc_idx = IDXW'(i);
        end
    end

    assign sel_mask = WIDTH'(1) << enc_idx;
    assign single   = (pend_q & (pend_q - WIDTH'(1))) == '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        bus.in_ready  = (state_q == IDLE) && rst_n;
        bus.out_valid = 1'b0;
        bus.out_idx   = '0;
        bus.out_last  = 1'b0;
        bus.out_none  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    pend_d  = bus.in_vec;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                bus.out_valid = 1'b1;
                bus.out_idx   = enc_idx;
                bus.out_last  = single;
                // pend is only empty in SCAN when the captured vector was zero
                bus.out_none  = (pend_q == '0);
                if (bus.out_ready) begin
                    pend_d = pend_q & ~sel_mask;
                    if (single) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PENC_POPCOUNT_EN
    function automatic logic [IDXW:0] popcnt(input logic [WIDTH-1:0] v);
        logic [IDXW:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++)
            c = c + (IDXW+1)'(v[i]);
        return c;
    endfunction

    logic [IDXW:0] pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n || state_d == IDLE) begin
            pc_q <= '0;
        end else if (state_q == IDLE) begin
            pc_q <= popcnt(bus.in_vec);
        end
    end

    assign bus.pop_count = pc_q;
`endif

endmodule

// File: tb/tb_p_encoder_stream.sv
// tb/tb_p_encoder_stream.sv - scoreboard bench for p_encoder_stream (8-bit MSB/LSB-first and 5-bit instances)
module tb_p_encoder_stream;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    p_encoder_stream_if #(.WIDTH(8)) bm ();
    p_encoder_stream_if #(.WIDTH(8)) bl ();
    p_encoder_stream_if #(.WIDTH(5)) b5 ();

    p_encoder_stream #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m  (.clk(clk), .rst_n(rst_n), .bus(bm));
    p_encoder_stream #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l  (.clk(clk), .rst_n(rst_n), .bus(bl));
    p_encoder_stream #(.WIDTH(5), .MSB_FIRST(1'b0)) u_l5 (.clk(clk), .rst_n(rst_n), .bus(b5));

    typedef struct {
        logic [2:0] idx;
        logic       last;
        logic       none;
        logic [3:0] pc;
    } beat_t;

    typedef struct {
        logic [7:0] vec;
        int         beats;
        int         first;
    } vec_t;

    beat_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    beats_seen = 0;
    int    first_idx = 0;
    logic  rdy = 1'b1;
    logic  rand_bp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        bm.out_ready = rand_bp ? 1'($urandom_range(0, 1)) : rdy;
    end

    // Scoreboard monitor plus hold-under-backpressure check for the main instance.
    beat_t stall_b;
    logic  stall_prev = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            if (stall_prev) begin
                chk("hold_valid", 32'(bm.out_valid), 1);
                chk("hold_idx",   32'(bm.out_idx),   32'(stall_b.idx));
                chk("hold_last",  32'(bm.out_last),  32'(stall_b.last));
                chk("hold_none",  32'(bm.out_none),  32'(stall_b.none));
            end
            if (bm.out_valid && bm.out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: idx %0d with no expected beat", bm.out_idx);
                end else begin
                    e = q.pop_front();
                    if (beats_seen == 0) first_idx = int'(bm.out_idx);
                    beats_seen++;
                    chk("beat_idx",  32'(bm.out_idx),  32'(e.idx));
                    chk("beat_last", 32'(bm.out_last), 32'(e.last));
                    chk("beat_none", 32'(bm.out_none), 32'(e.none));
`ifdef PENC_POPCOUNT_EN
                    chk("beat_pop_count", 32'(bm.pop_count), 32'(e.pc));
`endif
                end
            end
            stall_prev   = bm.out_valid && !bm.out_ready;
            stall_b.idx  = bm.out_idx;
            stall_b.last = bm.out_last;
            stall_b.none = bm.out_none;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic push_exp(input logic [7:0] v);
        beat_t b;
        int    cnt;
        int    k;
        cnt = $countones(v);
        k = 0;
        if (v == 8'h00) begin
            b = '{3'd0, 1'b1, 1'b1, 4'd0};
            q.push_back(b);
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) begin
                    k++;
                    b.idx  = 3'(i);
                    b.last = (k == cnt);
                    b.none = 1'b0;
                    b.pc   = 4'(cnt);
                    q.push_back(b);
                end
            end
        end
    endtask

    task automatic send(input logic [7:0] v);
        int n;
        n = 0;
        while (!bm.in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("send_in_ready_timeout", 32'(bm.in_ready), 1);
        beats_seen  = 0;
        bm.in_valid = 1'b1;
        bm.in_vec   = v;
        push_exp(v);
        @(posedge clk);
        #1;
        bm.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || bm.out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 32'(q.size()), 0);
        chk("drain_out_valid",   32'(bm.out_valid), 0);
`ifdef PENC_POPCOUNT_EN
        chk("idle_pop_count", 32'(bm.pop_count), 0);
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   el8[4];
        int   el5[2];

        tbl = '{'{8'hA6, 4, 7}, '{8'h00, 1, 0}, '{8'h81, 2, 7}, '{8'hFF, 8, 7},
                '{8'h01, 1, 0}, '{8'h80, 1, 7}, '{8'h5A, 4, 6}, '{8'h3C, 4, 5}};
        el8 = '{1, 2, 5, 7};
        el5 = '{0, 4};

        bm.in_valid = 1'b0; bm.in_vec = '0;
        bl.in_valid = 1'b0; bl.in_vec = '0; bl.out_ready = 1'b1;
        b5.in_valid = 1'b0; b5.in_vec = '0; b5.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bm.out_valid), 0);
        chk("rst_in_ready",  32'(bm.in_ready),  0);
        chk("rst_out_idx",   32'(bm.out_idx),   0);
        chk("rst_out_last",  32'(bm.out_last),  0);
`ifdef PENC_POPCOUNT_EN
        chk("rst_pop_count", 32'(bm.pop_count), 0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(bm.in_ready), 1);

        for (int i = 0; i < 8; i++) begin
            rand_bp = (i % 2) == 1;
            send(tbl[i].vec);
            drain();
            chk("tbl_beat_count", 32'(beats_seen), 32'(tbl[i].beats));
            chk("tbl_first_idx",  32'(first_idx),  32'(tbl[i].first));
        end
        rand_bp = 1'b0;
        rdy = 1'b1;
        @(negedge clk);

        // Four back-to-back beats, then IDLE one cycle later.
        send(8'hA6);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("burst_valid", 32'(bm.out_valid), 1);
        end
        @(negedge clk);
        chk("burst_done_in_ready",  32'(bm.in_ready),  1);
        chk("burst_done_out_valid", 32'(bm.out_valid), 0);
        drain();

        // Backpressure: idx 7 held for 4 cycles before idx 0.
        rdy = 1'b0;
        send(8'h81);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_idx",  32'(bm.out_idx),  7);
            chk("bp_last", 32'(bm.out_last), 0);
        end
        rdy = 1'b1;
        @(negedge clk);
        chk("bp_idx4",  32'(bm.out_idx),  7);
        chk("bp_last4", 32'(bm.out_last), 0);
        @(negedge clk);
        chk("bp_final_idx",  32'(bm.out_idx),  0);
        chk("bp_final_last", 32'(bm.out_last), 1);
        drain();

        // Reset after the first beat of an all-ones vector.
        send(8'hFF);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(bm.in_ready), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        q.delete();
        @(negedge clk);
        chk("midrst_out_valid", 32'(bm.out_valid), 0);
        chk("midrst_out_idx",   32'(bm.out_idx),   0);
        chk("midrst_in_ready2", 32'(bm.in_ready),  1);
        send(8'h10);
        drain();
        chk("midrst_beats", 32'(beats_seen), 1);
        chk("midrst_first", 32'(first_idx),  4);

        // in_valid held through SCAN never sees in_ready.
        send(8'hA6);
        bm.in_valid = 1'b1;
        bm.in_vec   = 8'h3C;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("scan_in_ready", 32'(bm.in_ready), 0);
        end
        bm.in_valid = 1'b0;
        drain();
        chk("scan_beats", 32'(beats_seen), 4);

        // LSB-first, 8 bits.
        @(negedge clk);
        chk("l8_in_ready", 32'(bl.in_ready), 1);
        @(posedge clk);
        #1 bl.in_vec = 8'hA6; bl.in_valid = 1'b1;
        @(posedge clk);
        #1 bl.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("l8_valid", 32'(bl.out_valid), 1);
            chk("l8_idx",   32'(bl.out_idx),   32'(el8[k]));
            chk("l8_last",  32'(bl.out_last),  32'(k == 3));
        end
        @(negedge clk);
        chk("l8_done", 32'(bl.out_valid), 0);

        // LSB-first, 5 bits.
        @(posedge clk);
        #1 b5.in_vec = 5'b10001; b5.in_valid = 1'b1;
        @(posedge clk);
        #1 b5.in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("l5_valid", 32'(b5.out_valid), 1);
            chk("l5_idx",   32'(b5.out_idx),   32'(el5[k]));
            chk("l5_last",  32'(b5.out_last),  32'(k == 1));
        end
        @(negedge clk);
        chk("l5_done", 32'(b5.out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
